// File: rtl/axi4_stream_64b_16b_gbx_if.sv
// AXI4-Stream bundle shared by the wide (64-bit) and narrow (16-bit) sides of the gearbox.
// Keep/strb width follows the data width at one bit per byte.
interface axi4_stream_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 1,
  parameter int DEST_W = 1,
  parameter int ID_W   = 1
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic [DEST_W-1:0] tdest;
  logic [ID_W-1:0]   tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_64b_16b_gbx.sv
// 64-bit to 16-bit AXI4-Stream gearbox: holds one wide beat and emits it lane by lane,
// trimming the final beat of a packet to its highest populated lane.
module axi4_stream_64b_16b_gbx #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  axi4_stream_if.slave    pkt_i,
  axi4_stream_if.master   pkt_o
);

  typedef struct packed {
    logic [63:0]            data;
    logic [7:0]             keep;
    logic [7:0]             strb;
    logic                   last;
    logic [TUSER_WIDTH-1:0] user;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TID_WIDTH-1:0]   id;
  } beat_t;

  beat_t      beat_q, beat_d;
  logic       valid_q, valid_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] last_lane_q, last_lane_d;

  logic in_hs;
  logic out_hs;
  logic final_lane;

  // Non-last beats always go out in full; a last beat stops at its highest kept lane.
  function automatic logic [1:0] calc_last_lane(input logic last, input logic [7:0] keep);
    logic [1:0] ll;
    ll = 2'd3;
    if (last) begin
      ll = 2'd0;
      for (int n = 0; n < 4; n++) begin
        if (keep[2*n +: 2] != 2'b00) ll = n[1:0];
      end
    end
    return ll;
  endfunction

  assign final_lane = (lane_q == last_lane_q);
  assign out_hs     = pkt_o.tvalid & pkt_o.tready;
  assign in_hs      = pkt_i.tvalid & pkt_i.tready;

  // Refill in the same cycle the final lane leaves so a beat every 4 cycles streams gap-free.
  assign pkt_i.tready = ~valid_q | (out_hs & final_lane);

  assign pkt_o.tvalid = valid_q;
  assign pkt_o.tdata  = beat_q.data[{lane_q, 4'b0000} +: 16];
  assign pkt_o.tkeep  = beat_q.keep[{lane_q, 1'b0} +: 2];
  assign pkt_o.tstrb  = beat_q.strb[{lane_q, 1'b0} +: 2];
  assign pkt_o.tlast  = beat_q.last & final_lane;
  assign pkt_o.tuser  = (lane_q == 2'd0) ? beat_q.user : '0;
  assign pkt_o.tdest  = beat_q.dest;
  assign pkt_o.tid    = beat_q.id;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    beat_d      = beat_q;
    valid_d     = valid_q;
    lane_d      = lane_q;
    last_lane_d = last_lane_q;

    if (in_hs) begin
      beat_d.data = pkt_i.tdata;
      beat_d.keep = pkt_i.tkeep;
      beat_d.strb = pkt_i.tstrb;
      beat_d.last = pkt_i.tlast;
      beat_d.user = pkt_i.tuser;
      beat_d.dest = pkt_i.tdest;
      beat_d.id   = pkt_i.tid;
      valid_d     = 1'b1;
      lane_d      = 2'd0;
      last_lane_d = calc_last_lane(pkt_i.tlast, pkt_i.tkeep);
    end else if (out_hs) begin
      if (final_lane) begin
        valid_d = 1'b0;
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q      <= '0;
      valid_q     <= 1'b0;
      lane_q      <= 2'd0;
      last_lane_q <= 2'd0;
    end else begin
      beat_q      <= beat_d;
      valid_q     <= valid_d;
      lane_q      <= lane_d;
      last_lane_q <= last_lane_d;
    end
  end

endmodule

// File: tb/tb_axi4_stream_64b_16b_gbx.sv
// Self-checking bench for the 64b->16b gearbox: table vectors, directed corner sequences
// and a random-backpressure run scored against a lane-list reference model.
module tb_axi4_stream_64b_16b_gbx;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic        user;
    logic        dest;
    logic        id;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [1:0]  strb;
    logic        last;
    logic        user;
    logic        dest;
    logic        id;
  } word_t;

  typedef struct {
    beat_t beat;
    int    exp_n;
    word_t exp_final;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  axi4_stream_if #(.DATA_W(64), .USER_W(1), .DEST_W(1), .ID_W(1)) in_if ();
  axi4_stream_if #(.DATA_W(16), .USER_W(1), .DEST_W(1), .ID_W(1)) out_if ();

  axi4_stream_64b_16b_gbx #(
    .TUSER_WIDTH(1),
    .TDEST_WIDTH(1),
    .TID_WIDTH  (1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pkt_i(in_if),
    .pkt_o(out_if)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    words_out = 0;
  word_t last_word;
  word_t prev_word;
  bit    prev_stall = 0;

  beat_t src_q[$];
  word_t exp_q[$];
  int    acc_cycles[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of 16-bit words a beat produces on the narrow side.
  function automatic int n_lanes(input beat_t b);
    int hi;
    if (!b.last) return 4;
    hi = 0;
    for (int n = 0; n < 4; n++) if (b.keep[2*n +: 2] != 2'b00) hi = n;
    return hi + 1;
  endfunction

  function automatic void expand(input beat_t b);
    int    cnt;
    word_t w;
    cnt = n_lanes(b);
    for (int n = 0; n < cnt; n++) begin
      w.data = b.data[16*n +: 16];
      w.keep = b.keep[2*n +: 2];
      w.strb = b.strb[2*n +: 2];
      w.last = b.last && (n == cnt - 1);
      w.user = (n == 0) ? b.user : 1'b0;
      w.dest = b.dest;
      w.id   = b.id;
      exp_q.push_back(w);
    end
  endfunction

  function automatic word_t out_word();
    word_t w;
    w.data = out_if.tdata;
    w.keep = out_if.tkeep;
    w.strb = out_if.tstrb;
    w.last = out_if.tlast;
    w.user = out_if.tuser;
    w.dest = out_if.tdest;
    w.id   = out_if.tid;
    return w;
  endfunction

  // One clock: drive, settle, score against the model, advance to just after the edge.
  task automatic cycle(input logic out_ready);
    logic  in_v, in_hs, out_hs;
    int    sz;
    word_t cur;
    in_v = (src_q.size() != 0);
    in_if.tvalid = in_v;
    if (in_v) begin
      in_if.tdata = src_q[0].data;
      in_if.tkeep = src_q[0].keep;
      in_if.tstrb = src_q[0].strb;
      in_if.tlast = src_q[0].last;
      in_if.tuser = src_q[0].user;
      in_if.tdest = src_q[0].dest;
      in_if.tid   = src_q[0].id;
    end
    out_if.tready = out_ready;
    #1;
    sz  = exp_q.size();
    cur = out_word();
    check("out_tvalid", {63'd0, out_if.tvalid}, {63'd0, sz != 0});
    check("in_tready", {63'd0, in_if.tready}, {63'd0, (sz == 0) || (out_ready && sz == 1)});
    if (sz != 0) check("out_word", {40'd0, cur}, {40'd0, exp_q[0]});
    if (prev_stall) check("stall_hold", {40'd0, cur}, {40'd0, prev_word});
    prev_stall = out_if.tvalid && !out_ready;
    prev_word  = cur;
    in_hs  = in_v && in_if.tready;
    out_hs = out_if.tvalid && out_ready;
    if (out_hs) begin
      last_word = cur;
      words_out++;
      if (sz != 0) void'(exp_q.pop_front());
    end
    if (in_hs) begin
      expand(src_q[0]);
      acc_cycles.push_back(cyc);
      void'(src_q.pop_front());
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int k;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cycle(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    check("drain_done", 64'(src_q.size() + exp_q.size()), 64'd0);
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic u, input logic de, input logic i);
    beat_t b;
    b.data = d; b.keep = k; b.strb = k; b.last = l; b.user = u; b.dest = de; b.id = i;
    return b;
  endfunction

  localparam logic [63:0] D0 = 64'h4444_3333_2222_1111;

  vec_t  vecs[7];
  int    w0, a0, exp_total;
  beat_t b;

  initial begin
    vecs[0] = '{mk(D0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1), 4, '{16'h4444, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[1] = '{mk(D0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1), 2, '{16'h2222, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[2] = '{mk(D0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1), 1, '{16'h1111, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[3] = '{mk(D0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1), 1, '{16'h1111, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{mk(D0, 8'h30, 1'b1, 1'b1, 1'b0, 1'b1), 3, '{16'h3333, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{mk(D0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1), 4, '{16'h4444, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{mk(D0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0), 4, '{16'h4444, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0}};

    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tstrb = '0;
    in_if.tlast = 1'b0; in_if.tuser = '0; in_if.tdest = '0; in_if.tid = '0;
    out_if.tready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    check("rst_word", {40'd0, out_word()}, 64'd0);
    check("rst_in_tready", {63'd0, in_if.tready}, 64'd1);
    rst_i = 1'b0;
    #1;
    check("rel_in_tready", {63'd0, in_if.tready}, 64'd1);

    // Table-driven single-beat vectors.
    foreach (vecs[i]) begin
      w0 = words_out;
      src_q.push_back(vecs[i].beat);
      drain(50, 1'b0);
      check($sformatf("vec%0d_nwords", i), 64'(words_out - w0), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d_final", i), {40'd0, last_word}, {40'd0, vecs[i].exp_final});
    end

    // Trimmed last beat followed by another: second accepted as lane 1 leaves.
    a0 = acc_cycles.size();
    src_q.push_back(mk(D0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0));
    src_q.push_back(mk(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
    drain(50, 1'b0);
    check("trim_acc_count", 64'(acc_cycles.size() - a0), 64'd2);
    if (acc_cycles.size() - a0 == 2)
      check("trim_acc_gap", 64'(acc_cycles[a0+1] - acc_cycles[a0]), 64'd2);

    // Three-beat packet streamed gap-free.
    a0 = acc_cycles.size();
    w0 = words_out;
    src_q.push_back(mk(64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0));
    src_q.push_back(mk(64'h0008_0007_0006_0005, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
    src_q.push_back(mk(64'h000C_000B_000A_0009, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (13) cycle(1'b1);
    check("b2b_words", 64'(words_out - w0), 64'd12);
    check("b2b_acc_count", 64'(acc_cycles.size() - a0), 64'd3);
    if (acc_cycles.size() - a0 == 3) begin
      check("b2b_gap1", 64'(acc_cycles[a0+1] - acc_cycles[a0]), 64'd4);
      check("b2b_gap2", 64'(acc_cycles[a0+2] - acc_cycles[a0+1]), 64'd4);
    end
    drain(20, 1'b0);

    // Reset after lane 1 of a held beat.
    src_q.push_back(mk(D0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1));
    repeat (3) cycle(1'b1);
    rst_i = 1'b1;
    #1;
    check("midrst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    check("midrst_word", {40'd0, out_word()}, 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("midrst_in_tready", {63'd0, in_if.tready}, 64'd1);
    w0 = words_out;
    src_q.push_back(mk(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
    drain(50, 1'b0);
    check("midrst_next_words", 64'(words_out - w0), 64'd4);
    check("midrst_next_final", {48'd0, last_word.data}, 64'h8888);

    // Random beats under 50% output backpressure.
    w0 = words_out;
    exp_total = 0;
    for (int i = 0; i < 40; i++) begin
      b = mk({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      exp_total += n_lanes(b);
      src_q.push_back(b);
    end
    drain(3000, 1'b1);
    check("rand_words", 64'(words_out - w0), 64'(exp_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
